// File: rtl/mmio_irq_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmio_irq_pkg : register offsets, MODE encodings and event helper     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package mmio_irq_pkg;

  // Byte offsets within the 32-byte register window.
  localparam logic [4:0] REG_RAW  = 5'h00;
  localparam logic [4:0] REG_PEND = 5'h04;
  localparam logic [4:0] REG_EN   = 5'h08;
  localparam logic [4:0] REG_MODE = 5'h0C;
  localparam logic [4:0] REG_STAT = 5'h10;

  typedef enum logic [1:0] {
    MODE_RISE  = 2'b00,
    MODE_FALL  = 2'b01,
    MODE_BOTH  = 2'b10,
    MODE_LEVEL = 2'b11
  } irq_mode_e;

  // cur is the debounced value, prev the same value one cycle earlier.
  function automatic logic detect_event(input irq_mode_e mode, input logic cur,
                                        input logic prev);
    logic evt;
    case (mode)
      MODE_RISE: evt = cur & ~prev;
      MODE_FALL: evt = ~cur & prev;
      MODE_BOTH: evt = cur ^ prev;
      default:   evt = cur;
    endcase
    return evt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_irq_ctrl_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_debounce : two-flop synchroniser plus stable-count debouncer     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module irq_debounce
  import mmio_irq_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES = 16'd12000,
  parameter logic        INIT      = 1'b1
) (
  input  logic clock_main,
  input  logic rst_n,
  input  logic async_in,
  output logic db_out
);

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clock_main) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= async_in;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (DB_CYCLES == 16'd0) begin : g_bypass
      assign db_out = r_sync2;
    end else begin : g_filter
      logic [15:0] r_cnt;
      logic        r_db;

      // The counter only runs while the synchronised value disagrees.
      always_ff @(posedge clock_main) begin
        if (!rst_n) begin
          r_cnt <= 16'd0;
          r_db  <= INIT;
        end else if (r_sync2 == r_db) begin
          r_cnt <= 16'd0;
        end else if (r_cnt == DB_CYCLES) begin
          r_db  <= r_sync2;
          r_cnt <= 16'd0;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end

      assign db_out = r_db;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mmio_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmio_irq_ctrl : picorv32-bus interrupt controller, NCH inputs        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mmio_irq_ctrl
  import mmio_irq_pkg::*;
#(
  parameter int              NCH        = 4,
  parameter logic [31:0]     BASE_ADDR  = 32'h0200_5000,
  parameter logic [15:0]     DB_CYCLES  = 16'd12000,
  parameter logic [NCH-1:0]  INIT_LEVEL = {NCH{1'b1}}
) (
  input  logic           clock_main,
  input  logic           rst_n,
  input  logic           mem_valid,
  input  logic [31:0]    mem_addr,
  input  logic [31:0]    mem_wdata,
  input  logic [3:0]     mem_wstrb,
  output logic           mem_ready,
  output logic [31:0]    mem_rdata,
  input  logic [NCH-1:0] irq_in,
  output logic           irq_out
);

  localparam logic [31:0] c_ch_mask   = 32'((64'd1 << NCH) - 64'd1);
  localparam logic [31:0] c_mode_mask = 32'((64'd1 << (2 * NCH)) - 64'd1);

  // Registers are held at 32 bits; bits beyond the channel count stay 0.
  logic [31:0]    r_pend;
  logic [31:0]    r_en;
  logic [31:0]    r_mode;
  logic [NCH-1:0] r_prev;

  logic [NCH-1:0] w_db;
  logic [31:0]    w_raw;
  logic [31:0]    w_evt;
  logic [31:0]    w_stat;

  logic           w_hit;
  logic           w_rd;
  logic           w_wr;
  logic [4:0]     w_off;
  logic [31:0]    w_bmask;
  logic [31:0]    w_wmasked;
  logic           w_wr_pend;
  logic           w_wr_en;
  logic           w_wr_mode;
  logic [31:0]    w_pend_clr;
  logic [31:0]    w_pend_nxt;
  logic [31:0]    w_rdata;

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      irq_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .INIT      (INIT_LEVEL[i])
      ) u_debounce (
        .clock_main (clock_main),
        .rst_n      (rst_n),
        .async_in   (irq_in[i]),
        .db_out     (w_db[i])
      );

      assign w_evt[i] = detect_event(irq_mode_e'(r_mode[2*i +: 2]), w_db[i], r_prev[i]);
    end
  endgenerate

  assign w_evt[31:NCH] = '0;
  assign w_raw         = 32'(w_db);
  assign w_stat        = r_pend & r_en;

  // Bus decode: the !mem_ready term keeps each access to a single ack.
  assign w_hit     = mem_valid && !mem_ready && (mem_addr[31:5] == BASE_ADDR[31:5]);
  assign w_off     = mem_addr[4:0] & 5'h1C;
  assign w_wr      = w_hit && (mem_wstrb != 4'b0000);
  assign w_rd      = w_hit && (mem_wstrb == 4'b0000);
  assign w_bmask   = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}},
                      {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
  assign w_wmasked = mem_wdata & w_bmask;
  assign w_wr_pend = w_wr && (w_off == REG_PEND);
  assign w_wr_en   = w_wr && (w_off == REG_EN);
  assign w_wr_mode = w_wr && (w_off == REG_MODE);

  // A new event on the same edge as a W1C wins over the clear.
  assign w_pend_clr = w_wr_pend ? (w_wmasked & c_ch_mask) : 32'd0;
  assign w_pend_nxt = ((r_pend & ~w_pend_clr) | w_evt) & c_ch_mask;

  always_comb begin
    w_rdata = 32'd0;
    if (w_rd) begin
      case (w_off)
        REG_RAW:  w_rdata = w_raw;
        REG_PEND: w_rdata = r_pend;
        REG_EN:   w_rdata = r_en;
        REG_MODE: w_rdata = r_mode;
        REG_STAT: w_rdata = w_stat;
        default:  w_rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clock_main) begin
    if (!rst_n) begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
      irq_out   <= 1'b0;
      r_pend    <= 32'd0;
      r_en      <= 32'd0;
      r_mode    <= 32'd0;
      r_prev    <= INIT_LEVEL;
    end else begin
      mem_ready <= w_hit;
      mem_rdata <= w_rdata;
      irq_out   <= |w_stat;
      r_pend    <= w_pend_nxt;
      r_prev    <= w_db;
      if (w_wr_en) begin
        r_en <= ((r_en & ~w_bmask) | w_wmasked) & c_ch_mask;
      end
      if (w_wr_mode) begin
        r_mode <= ((r_mode & ~w_bmask) | w_wmasked) & c_mode_mask;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mmio_irq_ctrl.md
# mmio_irq_ctrl

Parametrised memory-mapped interrupt controller on the picorv32 native memory bus. It takes NCH asynchronous inputs, for example push-buttons or peripheral status lines. Each input is synchronised and debounced, then goes through per-channel edge or level detection with enable masking and write-1-to-clear pending bits. All pending, enabled channels combine into one registered interrupt line that drives one bit of the CPU `irq` vector.

## Interface
Parameters:
- `NCH`, 4: number of input channels, 1..16.
- `BASE_ADDR`, 32'h0200_5000: byte address of register 0, 32-byte aligned.
- `DB_CYCLES`, 16'd12000: number of stable cycles needed before the debounced state changes; 0 bypasses the debouncer.
- `INIT_LEVEL`, {NCH{1'b1}}: value loaded into the debounced state at reset.

Ports:
- `clock_main` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `mem_valid` in 1: CPU bus request.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte strobes; 0 means read.
- `mem_ready` out 1: one-cycle acknowledge.
- `mem_rdata` out 32: read data; 0 when `mem_ready` is low.
- `irq_in` in NCH: asynchronous inputs.
- `irq_out` out 1: registered interrupt request, level.

## Operation
Register map. Offsets are from `BASE_ADDR`. Unused bits read 0.
- 0x00 RAW, read-only: debounced input state.
- 0x04 PEND, W1C: pending bits.
- 0x08 EN, read/write: enable mask.
- 0x0C MODE, read/write: 2 bits per channel; channel i uses bits [2i+1:2i].
  - 00: rising edge.
  - 01: falling edge.
  - 10: both edges.
  - 11: level-high.
- 0x10 STAT, read-only: PEND & EN.
- 0x14..0x1C: reserved; reads return 0, writes are ignored, and the access is still acknowledged.

Bus access:
- A hit is `mem_valid && !mem_ready && mem_addr[31:5]==BASE_ADDR[31:5]`.
- A non-hit is never acknowledged; it is left to other slaves.
- Writes honour each strobe byte. Bits at positions ≥ NCH (≥ 2·NCH for MODE) are discarded.

Input path, per channel:
- Two-flop synchroniser, then the debouncer.
- The debouncer has a counter (16 bits) that resets whenever the synchronised value equals the debounced value.
- When the synchronised value has differed from the debounced value for DB_CYCLES consecutive edges, the debounced value takes the synchronised value and the counter clears.

Detection and pending:
- The event is computed from the debounced value and its one-cycle delayed copy, according to MODE.
- In level mode, the event is asserted on every cycle the debounced value is 1.
- An event sets the PEND bit regardless of EN.
- PEND bit i clears when bit i is written as 1. If an event occurs on the same edge, set wins.
- In level mode, clearing a channel whose input is still high leaves the bit set.

Output:
- `irq_out` is registered from |(PEND & EN).
- Writing EN=0 masks the interrupt but does not clear PEND.

Reset, synchronous:
- `mem_ready`, `mem_rdata`, `irq_out`, PEND, EN and MODE are 0.
- The debounced value and its delayed copy are INIT_LEVEL, so no spurious edge occurs after reset.
- Counters and synchroniser flops are 0.
- Reset asserted during a bus access drops that access; the CPU is in reset too.

## Timing
- Bus: `mem_ready` and `mem_rdata` are registered and asserted on the edge after a hit, for exactly one cycle. Read latency is 1 wait state, identical for writes.
- A write takes effect on the same edge that raises `mem_ready`. A read issued in the cycle after a write returns the new value.
- Input to IRQ, channel enabled, input edge sampled at edge t:
  - debounced value changes at t+2+DB_CYCLES.
  - PEND is set at t+3+DB_CYCLES.
  - `irq_out` rises at t+4+DB_CYCLES.
- With DB_CYCLES=0, the debounced value equals the synchroniser output.
- A glitch shorter than DB_CYCLES cycles produces no debounced change.
- PEND clear to `irq_out` low: 1 cycle after the W1C edge.

## Structure
- Shared package `mmio_irq_pkg` holds:
  - register offset constants (REG_RAW, REG_PEND, REG_EN, REG_MODE, REG_STAT);
  - MODE encodings (MODE_RISE, MODE_FALL, MODE_BOTH, MODE_LEVEL).
- One sub-module, `irq_debounce`: single channel, containing the synchroniser, counter and debounced flop, parameterised by DB_CYCLES and INIT bit. It is instantiated NCH times in a generate loop.
- Register decode, event detection, PEND/EN/MODE and the bus response stay in the top level.

## Test plan
- Reset with NCH=4, DB_CYCLES=4, inputs at 4'hF:
  - reads of RAW=0xF, PEND=0, EN=0, MODE=0 and STAT=0, each with `mem_ready` exactly 1 cycle after `mem_valid`;
  - `irq_out`=0.
- EN=0x1, MODE=01 (falling). Drive `irq_in[0]` low at edge t:
  - PEND=0x1 at t+7;
  - `irq_out`=1 at t+8.
  - A 3-cycle low pulse instead produces no PEND change.
- MODE ch1=11 (level), EN=0x2, `irq_in[1]` held high. Write PEND=0x2:
  - PEND bit 1 still reads 1;
  - after the input goes low, a W1C clears it and `irq_out` falls 1 cycle later.
- W1C of ch0 on the same edge as a new ch0 event: PEND bit 0 reads 1 afterwards.
- Byte-strobe write to MODE with wstrb=4'b0001 and wdata=0xFFFF_FFFF: MODE reads 0x0000_00FF.
- Access at BASE_ADDR+0x20 and at an unrelated address: `mem_ready` never asserted.
